// File: rtl/rmssd_window_engine_pkg.sv
// Shared types and width helpers for the streaming RMSSD engine.
// No logic: compile-time only.
// No handshake: consumed by the engine, its interface users and the sqrt core.
package rmssd_window_engine_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SQRT  = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam logic MODE_BLOCK   = 1'b0;
    localparam logic MODE_SLIDING = 1'b1;

    // Square of an RR difference.
    function automatic int sq_width(input int rr_w);
        return 2 * rr_w;
    endfunction

    // Sum of 2**win_log2 squares; sized so the window sum cannot overflow.
    function automatic int sum_width(input int rr_w, input int win_log2);
        return 2 * rr_w + win_log2;
    endfunction

endpackage

// File: rtl/rmssd_window_engine_if.sv
// RR-interval input stream, RMSSD result stream and window status.
// No logic: wires only.
// Both streams are valid/ready; the slave modport is the engine side.
interface rmssd_window_engine_if #(
    parameter int RR_W = 12
);
    logic            rr_valid;
    logic [RR_W-1:0] rr_data;
    logic            rr_ready;
    logic            rmssd_valid;
    logic [RR_W-1:0] rmssd_data;
    logic            rmssd_ready;
    logic            win_full;

    modport master (
        output rr_valid, rr_data, rmssd_ready,
        input  rr_ready, rmssd_valid, rmssd_data, win_full
    );

    modport slave (
        input  rr_valid, rr_data, rmssd_ready,
        output rr_ready, rmssd_valid, rmssd_data, win_full
    );
endinterface

// File: rtl/rmssd_window_engine_isqrt.sv
// Sequential digit-by-digit floor integer square root of a 2*ROOT_W-bit radicand.
// Latency: start -> done pulse ROOT_W+1 cycles later (one root bit per cycle).
// No backpressure: start is ignored while busy; abort cancels a run with no done.
// Ports: start/radicand in, busy/done/root out, abort = synchronous cancel.
module rmssd_window_engine_isqrt #(
    parameter int ROOT_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [ROOT_W-1:0]     root
);
    localparam int CNT_W = $clog2(ROOT_W + 1);

    logic [2*ROOT_W-1:0] x_q;
    logic [ROOT_W-1:0]   rem_q;
    logic [ROOT_W-1:0]   root_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;

    logic [ROOT_W+1:0]   rem_sh;
    logic [ROOT_W+1:0]   trial;
    logic                take;

    // Bring down the next two radicand bits and try appending a 1 to the root.
    // Before the last step the remainder never exceeds 2*root, so ROOT_W bits
    // hold it; the remainder left after the final step is never used.
    assign rem_sh = {rem_q, x_q[2*ROOT_W-1 -: 2]};
    assign trial  = {root_q, 2'b01};
    assign take   = (rem_sh >= trial);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start && !busy_q) begin
                x_q    <= radicand;
                rem_q  <= '0;
                root_q <= '0;
                cnt_q  <= CNT_W'(ROOT_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                x_q    <= {x_q[2*ROOT_W-3:0], 2'b00};
                rem_q  <= ROOT_W'(take ? rem_sh - trial : rem_sh);
                root_q <= {root_q[ROOT_W-2:0], take};
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/rmssd_window_engine.sv
// Streaming RMSSD: floor(sqrt(mean of squared successive RR differences)) over 2**WIN_LOG2 diffs.
// Latency: trigger sample accepted at edge t -> rmssd_valid high after edge t+RR_W+2.
// Backpressure: rr_ready low through sqrt and until the result is taken; nothing dropped.
// Ports: clk, rst_n (async low), clear (sync flush, latches mode), mode (0 block / 1 sliding),
//        bus (slave): rr_valid/rr_data/rr_ready in, rmssd_valid/rmssd_data/rmssd_ready out, win_full.
module rmssd_window_engine
    import rmssd_window_engine_pkg::*;
#(
    parameter int RR_W     = 12,
    parameter int WIN_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  mode,
    rmssd_window_engine_if.slave  bus
);
    localparam int N     = 1 << WIN_LOG2;
    localparam int SQ_W  = sq_width(RR_W);
    localparam int SUM_W = sum_width(RR_W, WIN_LOG2);
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    state_e               state_q, state_d;
    logic                 alive_q;
    logic                 mode_q;
    logic [RR_W-1:0]      prev_q;
    logic                 prev_vld_q;
    logic [SUM_W-1:0]     sum_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 win_full_q;
    logic [WIN_LOG2-1:0]  ptr_q;
    logic [SQ_W-1:0]      win_sq_q [N];
    logic [RR_W-1:0]      rmssd_data_q;

    logic                 rr_ready;
    logic                 accept, diff_accept, trigger, leave_out;
    logic [RR_W-1:0]      diff;
    logic [SQ_W-1:0]      diff_w, sq;
    logic [SUM_W-1:0]     sum_add, sum_nx;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 sqrt_start, sqrt_busy, sqrt_done;
    logic [RR_W-1:0]      sqrt_root;

    // alive_q holds rr_ready low until the first edge after reset release.
    assign rr_ready    = alive_q && (state_q == ACCUM) && !clear;
    assign accept      = bus.rr_valid && rr_ready;
    assign diff_accept = accept && prev_vld_q;

    assign diff    = (bus.rr_data >= prev_q) ? bus.rr_data - prev_q : prev_q - bus.rr_data;
    assign diff_w  = SQ_W'(diff);
    assign sq      = diff_w * diff_w;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Once the sliding window is full the oldest square leaves as the new one
    // enters; any intermediate wrap of sum_add cancels in the subtraction.
    assign sum_add = sum_q + SUM_W'(sq);
    assign sum_nx  = (mode_q == MODE_SLIDING && cnt_q == N_CNT)
                   ? sum_add - SUM_W'(win_sq_q[ptr_q]) : sum_add;

    assign trigger   = diff_accept && ((mode_q == MODE_BLOCK) ? (cnt_inc == N_CNT)
                                                              : (cnt_inc >= N_CNT));
    assign leave_out = (state_q == OUT) && bus.rmssd_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        sqrt_start = 1'b0;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (trigger) state_d = SQRT;
                SQRT: begin
                    if (sqrt_done)      state_d = OUT;
                    else if (!sqrt_busy) sqrt_start = 1'b1;
                end
                OUT:   if (bus.rmssd_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q      <= 1'b0;
            mode_q       <= MODE_BLOCK;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            sum_q        <= '0;
            cnt_q        <= '0;
            win_full_q   <= 1'b0;
            ptr_q        <= '0;
            rmssd_data_q <= '0;
        end else begin
            alive_q <= 1'b1;
            if (clear) begin
                mode_q     <= mode;
                prev_vld_q <= 1'b0;
                sum_q      <= '0;
                cnt_q      <= '0;
                win_full_q <= 1'b0;
                ptr_q      <= '0;
            end else begin
                if (accept) begin
                    prev_q     <= bus.rr_data;
                    prev_vld_q <= 1'b1;
                end
                if (diff_accept) begin
                    sum_q <= sum_nx;
                    if (cnt_q != N_CNT)    cnt_q      <= cnt_inc;
                    if (cnt_inc == N_CNT)  win_full_q <= 1'b1;
                    if (mode_q == MODE_SLIDING) ptr_q <= ptr_q + WIN_LOG2'(1);
                end
                if (state_q == SQRT && sqrt_done) rmssd_data_q <= sqrt_root;
                // Block mode starts each window afresh; prev is kept so the
                // next window's first diff spans the block boundary.
                if (leave_out && mode_q == MODE_BLOCK) begin
                    sum_q      <= '0;
                    cnt_q      <= '0;
                    win_full_q <= 1'b0;
                end
            end
        end
    end

    // Contents are only read once cnt_q shows they were rewritten since clear.
    always_ff @(posedge clk) begin
        if (!clear && diff_accept && mode_q == MODE_SLIDING) win_sq_q[ptr_q] <= sq;
    end

    rmssd_window_engine_isqrt #(.ROOT_W(RR_W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .abort    (clear),
        .start    (sqrt_start),
        .radicand (sum_q[SUM_W-1:WIN_LOG2]),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    assign bus.rr_ready    = rr_ready;
    assign bus.rmssd_valid = (state_q == OUT);
    assign bus.rmssd_data  = rmssd_data_q;
    assign bus.win_full    = win_full_q;

endmodule
